// File: rtl/simulador_esteira_pkg.sv
// Shared definitions for the bottling-line belt simulator: FSM encoding,
// default station positions and counter width.
package simulador_esteira_pkg;

    // Belt state, re-evaluated on every simulation step
    typedef enum logic [1:0] {
        PARADA   = 2'd0,
        TRANSITO = 2'd1,
        ENCHENDO = 2'd2
    } estado_t;

    // Default station positions along the 32-slot belt
    localparam int POS_ENCH_PADRAO   = 8;
    localparam int POS_CQ_PADRAO     = 16;
    localparam int POS_LACRE_PADRAO  = 24;
    localparam int POS_FIM_PADRAO    = 31;

    // Fill steps from empty to full
    localparam int FILL_TICKS_PADRAO = 10;

    // Width of the exit/discard bottle counters
    localparam int CONTADOR_W        = 8;

endpackage

// File: rtl/simulador_esteira_contador_saturado.sv
// Up-counter that sticks at its maximum value instead of wrapping.
module contador_saturado #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] valor
);

    // Count one per enabled cycle, holding at all-ones
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valor <= '0;
        end else if (inc && (valor != {W{1'b1}})) begin
            valor <= valor + W'(1);
        end
    end

endmodule

// File: rtl/simulador_esteira.sv
// Single-bottle conveyor belt simulator. Advances one simulation step per
// STEP_EN strobe, reacting to the controller commands and reporting the
// bottle position, fill level, seal status and station sensors. The FSM
// state is exposed on ESTADO for observation.
module simulador_esteira
    import simulador_esteira_pkg::*;
#(
    parameter int POS_ENCH   = POS_ENCH_PADRAO,
    parameter int POS_CQ     = POS_CQ_PADRAO,
    parameter int POS_LACRE  = POS_LACRE_PADRAO,
    parameter int POS_FIM    = POS_FIM_PADRAO,
    parameter int FILL_TICKS = FILL_TICKS_PADRAO
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  STEP_EN,
    input  logic                  MOTOR,
    input  logic                  VALVULA_ENCHIMENTO,
    input  logic                  ATUADOR_VEDACAO,
    input  logic                  DESCARTE,
    output logic                  SENSOR_POS_ENCHIMENTO,
    output logic                  SENSOR_POS_CQ,
    output logic                  SENSOR_POS_LACRE,
    output logic                  SENSOR_GARRAFA_CHEIA,
    output logic [4:0]            POSICAO,
    output logic [3:0]            NIVEL,
    output logic                  GARRAFA_VEDADA,
    output logic [CONTADOR_W-1:0] CONTA_SAIDA,
    output logic [CONTADOR_W-1:0] CONTA_DESCARTE,
    output logic                  ERRO_DERRAMAMENTO,
    output estado_t               ESTADO
);

    logic    em_ench;
    logic    em_cq;
    logic    em_fim;
    logic    cheia;
    logic    descarta;
    logic    sai;
    estado_t estado_prox;

    assign em_ench  = (POSICAO == 5'(POS_ENCH));
    assign em_cq    = (POSICAO == 5'(POS_CQ));
    assign em_fim   = (POSICAO == 5'(POS_FIM));
    assign cheia    = (NIVEL == 4'(FILL_TICKS));

    // Discard wins over motion: a bottle pulled at QC never advances
    assign descarta = DESCARTE && em_cq;
    assign sai      = MOTOR && em_fim && !descarta;

    // Sensors follow the registered position/level directly
    assign SENSOR_POS_ENCHIMENTO = em_ench;
    assign SENSOR_POS_CQ         = em_cq;
    assign SENSOR_POS_LACRE      = (POSICAO == 5'(POS_LACRE));
    assign SENSOR_GARRAFA_CHEIA  = cheia;

    // Classify the current step from the commands and the bottle position
    always_comb begin
        estado_prox = PARADA;
        if (MOTOR) begin
            estado_prox = TRANSITO;
        end else if (VALVULA_ENCHIMENTO && em_ench) begin
            estado_prox = ENCHENDO;
        end
    end

    // Bottle state machine: position, level, seal and spill flag per step
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            ESTADO            <= PARADA;
            POSICAO           <= '0;
            NIVEL             <= '0;
            GARRAFA_VEDADA    <= 1'b0;
            ERRO_DERRAMAMENTO <= 1'b0;
        end else if (STEP_EN) begin
            ESTADO <= estado_prox;
            if (VALVULA_ENCHIMENTO && (MOTOR || !em_ench || cheia)) begin
                ERRO_DERRAMAMENTO <= 1'b1;
            end
            if (descarta || sai) begin
                // Bottle leaves the belt; a fresh empty one enters at 0
                POSICAO        <= '0;
                NIVEL          <= '0;
                GARRAFA_VEDADA <= 1'b0;
            end else begin
                if (MOTOR) begin
                    POSICAO <= POSICAO + 5'd1;
                end
                if ((estado_prox == ENCHENDO) && !cheia) begin
                    NIVEL <= NIVEL + 4'd1;
                end
                if (ATUADOR_VEDACAO && em_ench && cheia) begin
                    GARRAFA_VEDADA <= 1'b1;
                end
            end
        end
    end

    contador_saturado #(.W(CONTADOR_W)) u_conta_saida (
        .clk   (CLK),
        .rst_n (RESET),
        .inc   (STEP_EN && sai),
        .valor (CONTA_SAIDA)
    );

    contador_saturado #(.W(CONTADOR_W)) u_conta_descarte (
        .clk   (CLK),
        .rst_n (RESET),
        .inc   (STEP_EN && descarta),
        .valor (CONTA_DESCARTE)
    );

endmodule

// File: tb/tb_simulador_esteira.sv
// Bench for simulador_esteira: directed scenarios plus randomized steps,
// compared against a behavioural model of the belt rules.
module tb_simulador_esteira;
    import simulador_esteira_pkg::*;

    localparam int PE = 8, PQ = 16, PL = 24, PF = 31, FT = 10;

    logic       CLK = 1'b0;
    logic       RESET = 1'b0;
    logic       STEP_EN = 1'b0;
    logic       MOTOR = 1'b0, VALVULA_ENCHIMENTO = 1'b0, ATUADOR_VEDACAO = 1'b0, DESCARTE = 1'b0;
    logic       SENSOR_POS_ENCHIMENTO, SENSOR_POS_CQ, SENSOR_POS_LACRE, SENSOR_GARRAFA_CHEIA;
    logic [4:0] POSICAO;
    logic [3:0] NIVEL;
    logic       GARRAFA_VEDADA;
    logic [7:0] CONTA_SAIDA, CONTA_DESCARTE;
    logic       ERRO_DERRAMAMENTO;
    estado_t    ESTADO;

    int checks = 0;
    int failures = 0;

    // Reference model state
    int m_pos, m_niv, m_ved, m_err, m_sai, m_desc;
    estado_t m_est;

    simulador_esteira dut (
        .CLK(CLK), .RESET(RESET), .STEP_EN(STEP_EN),
        .MOTOR(MOTOR), .VALVULA_ENCHIMENTO(VALVULA_ENCHIMENTO),
        .ATUADOR_VEDACAO(ATUADOR_VEDACAO), .DESCARTE(DESCARTE),
        .SENSOR_POS_ENCHIMENTO(SENSOR_POS_ENCHIMENTO), .SENSOR_POS_CQ(SENSOR_POS_CQ),
        .SENSOR_POS_LACRE(SENSOR_POS_LACRE), .SENSOR_GARRAFA_CHEIA(SENSOR_GARRAFA_CHEIA),
        .POSICAO(POSICAO), .NIVEL(NIVEL), .GARRAFA_VEDADA(GARRAFA_VEDADA),
        .CONTA_SAIDA(CONTA_SAIDA), .CONTA_DESCARTE(CONTA_DESCARTE),
        .ERRO_DERRAMAMENTO(ERRO_DERRAMAMENTO), .ESTADO(ESTADO)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pos = 0; m_niv = 0; m_ved = 0; m_err = 0; m_sai = 0; m_desc = 0;
        m_est = PARADA;
    endtask

    // One simulation step applied with the belt rules
    task automatic model_step(input bit m, input bit v, input bit a, input bit d);
        int p, n;
        p = m_pos;
        n = m_niv;
        if (m)                   m_est = TRANSITO;
        else if (v && p == PE)   m_est = ENCHENDO;
        else                     m_est = PARADA;
        if (v && (m || p != PE || n == FT)) m_err = 1;
        if (d && p == PQ) begin
            m_pos = 0; m_niv = 0; m_ved = 0;
            if (m_desc < 255) m_desc++;
        end else begin
            if (a && p == PE && n == FT) m_ved = 1;
            if (m_est == ENCHENDO && n < FT) m_niv = n + 1;
            if (m) begin
                if (p == PF) begin
                    m_pos = 0; m_niv = 0; m_ved = 0;
                    if (m_sai < 255) m_sai++;
                end else begin
                    m_pos = p + 1;
                end
            end
        end
    endtask

    task automatic compare_all(input string tag);
        check({tag, "_pos"},   POSICAO, m_pos);
        check({tag, "_niv"},   NIVEL, m_niv);
        check({tag, "_ved"},   GARRAFA_VEDADA, m_ved);
        check({tag, "_err"},   ERRO_DERRAMAMENTO, m_err);
        check({tag, "_sai"},   CONTA_SAIDA, m_sai);
        check({tag, "_desc"},  CONTA_DESCARTE, m_desc);
        check({tag, "_est"},   ESTADO, m_est);
        check({tag, "_s_en"},  SENSOR_POS_ENCHIMENTO, (m_pos == PE));
        check({tag, "_s_cq"},  SENSOR_POS_CQ, (m_pos == PQ));
        check({tag, "_s_lac"}, SENSOR_POS_LACRE, (m_pos == PL));
        check({tag, "_s_full"}, SENSOR_GARRAFA_CHEIA, (m_niv == FT));
    endtask

    // Called just after a rising edge; applies one step and returns just after the next
    task automatic do_step(input bit m, input bit v, input bit a, input bit d);
        MOTOR = m; VALVULA_ENCHIMENTO = v; ATUADOR_VEDACAO = a; DESCARTE = d;
        STEP_EN = 1'b1;
        @(posedge CLK); #1;
        STEP_EN = 1'b0;
        MOTOR = 1'b0; VALVULA_ENCHIMENTO = 1'b0; ATUADOR_VEDACAO = 1'b0; DESCARTE = 1'b0;
        model_step(m, v, a, d);
    endtask

    // Random commands without a step strobe: nothing may change
    task automatic idle_cycle();
        MOTOR = 1'($urandom); VALVULA_ENCHIMENTO = 1'($urandom);
        ATUADOR_VEDACAO = 1'($urandom); DESCARTE = 1'($urandom);
        STEP_EN = 1'b0;
        @(posedge CLK); #1;
        MOTOR = 1'b0; VALVULA_ENCHIMENTO = 1'b0; ATUADOR_VEDACAO = 1'b0; DESCARTE = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge CLK);
        RESET = 1'b0;
        #1;
        model_reset();
        compare_all("reset");
        @(negedge CLK);
        RESET = 1'b1;
        @(posedge CLK); #1;
    endtask

    initial begin
        model_reset();
        #2;
        compare_all("por");
        apply_reset();

        // Transit to the filling station
        for (int i = 0; i < 8; i++) do_step(1, 0, 0, 0);
        compare_all("transit");
        check("transit_pos8", POSICAO, 8);

        // Hold without strobe
        for (int i = 0; i < 3; i++) idle_cycle();
        compare_all("hold");

        // Fill to full, then overfill
        for (int i = 0; i < 10; i++) do_step(0, 1, 0, 0);
        compare_all("fill");
        check("fill_full", SENSOR_GARRAFA_CHEIA, 1);
        check("fill_noerr", ERRO_DERRAMAMENTO, 0);
        do_step(0, 1, 0, 0);
        compare_all("overfill");
        check("overfill_err", ERRO_DERRAMAMENTO, 1);

        // Seal and exit
        do_step(0, 0, 1, 0);
        compare_all("seal");
        check("seal_ved", GARRAFA_VEDADA, 1);
        for (int i = 0; i < 24; i++) do_step(1, 0, 0, 0);
        compare_all("exit");
        check("exit_sai", CONTA_SAIDA, 1);

        // Discard priority over motion at QC
        for (int i = 0; i < 16; i++) do_step(1, 0, 0, 0);
        do_step(1, 0, 0, 1);
        compare_all("discard");
        check("discard_pos0", POSICAO, 0);
        check("discard_cnt", CONTA_DESCARTE, 1);

        // Seal attempt on a non-full bottle has no effect
        apply_reset();
        for (int i = 0; i < 8; i++) do_step(1, 0, 0, 0);
        for (int i = 0; i < 3; i++) do_step(0, 1, 0, 0);
        do_step(0, 0, 1, 0);
        compare_all("seal_early");

        // Spill while moving keeps the level
        do_step(1, 1, 0, 0);
        compare_all("spill_move");
        check("spill_niv", NIVEL, 3);
        check("spill_err", ERRO_DERRAMAMENTO, 1);

        // Asynchronous reset in the middle of a fill
        apply_reset();
        for (int i = 0; i < 8; i++) do_step(1, 0, 0, 0);
        for (int i = 0; i < 5; i++) do_step(0, 1, 0, 0);
        check("midfill_niv5", NIVEL, 5);
        #2;
        RESET = 1'b0;
        #1;
        model_reset();
        compare_all("async_rst");
        #1;
        RESET = 1'b1;
        @(posedge CLK); #1;
        do_step(1, 0, 0, 0);
        compare_all("resume");

        // Randomized steps interleaved with idle cycles
        apply_reset();
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                idle_cycle();
                compare_all("rnd_idle");
            end else begin
                do_step($urandom_range(0, 9) < 6, $urandom_range(0, 9) < 3,
                        $urandom_range(0, 9) < 3, $urandom_range(0, 9) < 4);
                compare_all("rnd");
            end
            if ($urandom_range(0, 199) == 0) apply_reset();
        end

        // Exit counter saturation: 260 full laps
        apply_reset();
        for (int i = 0; i < 260 * 32; i++) do_step(1, 0, 0, 0);
        compare_all("sat");
        check("sat_255", CONTA_SAIDA, 255);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
